// File: rtl/tpu_result_writer_if.sv
// Result-beat input and RAM write-port bundle for the tile write-back stage.
// master = the result writer; slave = the array/RAM side that feeds and observes it.
interface tpu_result_writer_if #(
  parameter int LANES = 4,
  parameter int ACC_W = 16
);
  logic                   res_valid;
  logic [LANES*ACC_W-1:0] res_arr;
  logic                   wr_en;
  logic [5:0]             wr_addr;
  logic [7:0]             wr_data;

  modport master (
    input  res_valid, res_arr,
    output wr_en, wr_addr, wr_data
  );

  modport slave (
    output res_valid, res_arr,
    input  wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/tpu_result_writer.sv
// Collects a tile of accumulator beats, clamps each lane to an 8-bit pixel and
// streams the tile into the output region of the pixel RAM, then signals done.
module tpu_result_writer #(
  parameter int LANES     = 4,
  parameter int ACC_W     = 16,
  parameter int NPIX      = 16,
  parameter int BASE_ADDR = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  tpu_result_writer_if.master bus,
  output logic                done,
  output logic                overrun
);

  localparam int BEATS  = NPIX / LANES;
  localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WIDX_W = $clog2(NPIX);

  localparam logic signed [ACC_W-1:0] ACC_ZERO = '0;
  localparam logic signed [ACC_W-1:0] PIX_MAX  = ACC_W'(255);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;
  logic                overrun_q, overrun_d;
  logic                cap_en;
  logic [7:0]          pix_q [NPIX];
  logic [7:0]          pix_d [NPIX];

  function automatic logic [7:0] clamp_pix(input logic signed [ACC_W-1:0] v);
    if (v < ACC_ZERO)
      return 8'd0;
    else if (v > PIX_MAX)
      return 8'hFF;
    else
      return v[7:0];
  endfunction

  // Control state: async active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      bcnt_q    <= '0;
      widx_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      widx_q    <= widx_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    widx_d    = widx_q;
    overrun_d = overrun_q;
    cap_en    = 1'b0;

    // Any beat seen outside COLLECT is flagged and dropped.
    if (bus.res_valid && (state_q != S_COLLECT))
      overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_COLLECT;
          bcnt_d  = '0;
        end
      end
      S_COLLECT: begin
        if (bus.res_valid) begin
          cap_en = 1'b1;
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == BCNT_W'(BEATS - 1)) begin
            state_d = S_WRITE;
            widx_d  = '0;
          end
        end
      end
      S_WRITE: begin
        widx_d = widx_q + 1'b1;
        if (widx_q == WIDX_W'(NPIX - 1))
          state_d = S_DONE;
      end
      S_DONE: begin
        // Restart wins over a same-edge stray beat: the flag is cleared, not set.
        if (start) begin
          state_d   = S_COLLECT;
          bcnt_d    = '0;
          overrun_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pixel buffer: data only, contents are don't-care after reset
  always_comb begin
    pix_d = pix_q;
    if (cap_en) begin
      for (int l = 0; l < LANES; l++) begin
        pix_d[WIDX_W'(int'(bcnt_q) * LANES + l)] =
          clamp_pix($signed(bus.res_arr[l*ACC_W +: ACC_W]));
      end
    end
  end

  always_ff @(posedge clk) begin
    pix_q <= pix_d;
  end

  // Outputs decoded from registered state only, so reset drops them at once
  always_comb begin
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    if (state_q == S_WRITE) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 6'(BASE_ADDR) + 6'(widx_q);
      bus.wr_data = pix_q[widx_q];
    end
  end

  always_comb begin
    done    = (state_q == S_DONE);
    overrun = overrun_q;
  end

endmodule

// File: tb/tb_tpu_result_writer.sv
// Randomised bench for tpu_result_writer: a transaction-level reference model is
// compared against the outputs every cycle, with literal checks for key scenarios.
module tb_tpu_result_writer;

  logic clk;
  logic reset;
  logic start;
  logic done;
  logic overrun;

  int tests = 0;
  int fails = 0;

  tpu_result_writer_if #(.LANES(4), .ACC_W(16)) bus ();

  tpu_result_writer #(
    .LANES(4), .ACC_W(16), .NPIX(16), .BASE_ADDR(32)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .bus(bus), .done(done), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: phase 0 idle, 1 collecting, 2 writing, 3 done
  int m_phase = 0;
  int m_beats = 0;
  int m_wpos  = 0;
  int m_tile [16];
  bit m_ovr   = 1'b0;

  int obs_addr [$];
  int obs_data [$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampi(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_phase = 0; m_beats = 0; m_wpos = 0; m_ovr = 1'b0;
      end else begin
        case (m_phase)
          0: begin
            if (bus.res_valid) m_ovr = 1'b1;
            if (start) begin m_phase = 1; m_beats = 0; end
          end
          1: begin
            if (bus.res_valid) begin
              for (int l = 0; l < 4; l++)
                m_tile[4*m_beats + l] = clampi(int'($signed(bus.res_arr[l*16 +: 16])));
              m_beats++;
              if (m_beats == 4) begin m_phase = 2; m_wpos = 0; end
            end
          end
          2: begin
            if (bus.res_valid) m_ovr = 1'b1;
            m_wpos++;
            if (m_wpos == 16) m_phase = 3;
          end
          default: begin
            if (start) begin m_phase = 1; m_beats = 0; m_ovr = 1'b0; end
            else if (bus.res_valid) m_ovr = 1'b1;
          end
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("wr_en",   int'(bus.wr_en),   (m_phase == 2) ? 1 : 0);
      chk("wr_addr", int'(bus.wr_addr), (m_phase == 2) ? 32 + m_wpos : 0);
      chk("wr_data", int'(bus.wr_data), (m_phase == 2) ? m_tile[m_wpos] : 0);
      chk("done",    int'(done),        (m_phase == 3) ? 1 : 0);
      chk("overrun", int'(overrun),     int'(m_ovr));
      if (bus.wr_en === 1'b1) begin
        obs_addr.push_back(int'(bus.wr_addr));
        obs_data.push_back(int'(bus.wr_data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input int v0, input int v1, input int v2, input int v3,
                           input int stall);
    for (int s = 0; s < stall; s++) begin
      bus.res_valid = 1'b0;
      tick();
    end
    bus.res_arr[15:0]  = 16'(v0);
    bus.res_arr[31:16] = 16'(v1);
    bus.res_arr[47:32] = 16'(v2);
    bus.res_arr[63:48] = 16'(v3);
    bus.res_valid = 1'b1;
    tick();
    bus.res_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    if (done !== 1'b1) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
  endtask

  task automatic chk_ramp(input string name);
    chk({name, "_nwrites"}, obs_addr.size(), 16);
    for (int i = 0; i < 16 && i < obs_addr.size(); i++) begin
      chk({name, "_addr"}, obs_addr[i], 32 + i);
      chk({name, "_data"}, obs_data[i], i);
    end
  endtask

  function automatic int rand_lane();
    case ($urandom_range(0, 3))
      0: return int'($urandom_range(0, 255));
      1: return -int'($urandom_range(1, 32768));
      2: return int'($urandom_range(256, 32767));
      default: return int'($signed(16'($urandom)));
    endcase
  endfunction

  initial begin
    int clampv [8];
    reset = 1'b0;
    start = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_arr = '0;

    // Reset, then idle with no stimulus
    repeat (3) tick();
    reset = 1'b1;
    repeat (10) tick();
    chk("idle_wr_en", int'(bus.wr_en), 0);
    chk("idle_done", int'(done), 0);
    chk("idle_overrun", int'(overrun), 0);

    // Nominal tile with back-to-back beats, done timing pinned
    clear_obs();
    do_start();
    for (int b = 0; b < 4; b++) send_beat(4*b, 4*b+1, 4*b+2, 4*b+3, 0);
    chk("nom_first_write", int'(bus.wr_en), 1);
    repeat (15) tick();
    chk("nom_last_write", int'(bus.wr_en), 1);
    chk("nom_done_early", int'(done), 0);
    tick();
    chk("nom_done_rise", int'(done), 1);
    chk("nom_wr_en_off", int'(bus.wr_en), 0);
    repeat (3) tick();
    chk("nom_done_held", int'(done), 1);
    chk("nom_overrun", int'(overrun), 0);
    chk_ramp("nom");

    // Restart from DONE with a stray beat on the same edge
    start = 1'b1;
    bus.res_valid = 1'b1;
    bus.res_arr = {16'd9, 16'd9, 16'd9, 16'd9};
    tick();
    start = 1'b0;
    bus.res_valid = 1'b0;
    chk("restart_done", int'(done), 0);
    chk("restart_overrun", int'(overrun), 0);

    // Clamp boundaries, with a stray beat during WRITE
    clear_obs();
    send_beat(-1, 0, 255, 256, 0);
    send_beat(32'h7FFF, -32768, 128, 1, 0);
    send_beat(5, 6, 7, 8, 0);
    send_beat(300, -300, 77, 200, 0);
    repeat (4) tick();
    send_beat(1, 1, 1, 1, 0);
    chk("ovr_in_write", int'(overrun), 1);
    wait_done(40, "clamp");
    clampv = '{0, 0, 255, 255, 255, 0, 128, 1};
    chk("clamp_nwrites", obs_addr.size(), 16);
    for (int i = 0; i < 8 && i < obs_data.size(); i++) begin
      chk("clamp_addr", obs_addr[i], 32 + i);
      chk("clamp_data", obs_data[i], clampv[i]);
    end
    if (obs_data.size() >= 16) begin
      chk("clamp_tail12", obs_data[12], 255);
      chk("clamp_tail13", obs_data[13], 0);
    end

    // Stalled input: three idle cycles between every beat
    clear_obs();
    do_start();
    chk("stall_ovr_cleared", int'(overrun), 0);
    for (int b = 0; b < 3; b++) send_beat(4*b, 4*b+1, 4*b+2, 4*b+3, 3);
    repeat (3) tick();
    chk("stall_no_early_write", obs_addr.size(), 0);
    send_beat(12, 13, 14, 15, 0);
    wait_done(40, "stall");
    chk_ramp("stall");

    // Reset during write index 7
    do_start();
    for (int b = 0; b < 4; b++) send_beat(50 + b, 60 + b, 70 + b, 80 + b, 0);
    repeat (7) tick();
    chk("pre_reset_addr", int'(bus.wr_addr), 39);
    reset = 1'b0;
    #1;
    chk("reset_wr_en", int'(bus.wr_en), 0);
    chk("reset_wr_addr", int'(bus.wr_addr), 0);
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // Beat in IDLE stays flagged across IDLE->COLLECT
    send_beat(1, 2, 3, 4, 0);
    chk("idle_beat_ovr", int'(overrun), 1);
    clear_obs();
    do_start();
    chk("ovr_kept_on_start", int'(overrun), 1);
    for (int b = 0; b < 4; b++) send_beat(4*b, 4*b+1, 4*b+2, 4*b+3, 0);
    wait_done(40, "fresh");
    chk_ramp("fresh");

    // Randomised tiles with stalls, ignored starts and stray beats
    for (int t = 0; t < 12; t++) begin
      start = 1'b1;
      bus.res_valid = ($urandom_range(0, 3) == 0);
      tick();
      start = 1'b0;
      bus.res_valid = 1'b0;
      for (int b = 0; b < 4; b++) begin
        int st = $urandom_range(0, 3);
        for (int s = 0; s < st; s++) begin
          start = ($urandom_range(0, 2) == 0);
          tick();
        end
        start = 1'b0;
        send_beat(rand_lane(), rand_lane(), rand_lane(), rand_lane(), 0);
      end
      for (int c = 0; c < 18; c++) begin
        bus.res_valid = ($urandom_range(0, 7) == 0);
        start = ($urandom_range(0, 5) == 0) && (done !== 1'b1);
        bus.res_arr = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
        tick();
      end
      bus.res_valid = 1'b0;
      start = 1'b0;
      wait_done(40, "rand");
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
